// File: rtl/dcache_wb.sv
// dcache_wb: set-associative write-back, write-allocate data cache with a word-serial memory port.
// Latency: hit -> rd_data one edge later; clean miss stalls 2^LINE_ADDR_LEN+1 cycles, dirty adds 2^LINE_ADDR_LEN.
// Backpressure: miss stalls the requester; mem_ack gaps stretch bursts. Option macro DCACHE_LRU_EN: true LRU, else FIFO.
module dcache_wb #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int SET_ADDR_LEN  = 3,
  parameter int WAY_CNT       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_be,
  output logic [31:0] rd_data,
  output logic        miss,
  output logic        mem_rd_req,
  output logic        mem_wr_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] miss_cnt
);
  localparam int WORDS   = 1 << LINE_ADDR_LEN;
  localparam int SETS    = 1 << SET_ADDR_LEN;
  localparam int TAG_LEN = 30 - LINE_ADDR_LEN - SET_ADDR_LEN;
  localparam int WAY_W   = (WAY_CNT > 1) ? $clog2(WAY_CNT) : 1;

  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

  state_t                   state_q, state_d;
  logic [LINE_ADDR_LEN-1:0] beat_q, beat_d;
  logic [WAY_W-1:0]         vic_q, vic_d;
  logic [31:0]              rd_data_q, rd_data_d, mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [31:0]              miss_cnt_q, miss_cnt_d;
  logic                     mem_rd_req_q, mem_rd_req_d, mem_wr_req_q, mem_wr_req_d;
  logic [TAG_LEN-1:0]       tag_q [SETS][WAY_CNT];
  logic [TAG_LEN-1:0]       tag_d [SETS][WAY_CNT];
  logic [WAY_CNT-1:0]       valid_q [SETS];
  logic [WAY_CNT-1:0]       valid_d [SETS];
  logic [WAY_CNT-1:0]       dirty_q [SETS];
  logic [WAY_CNT-1:0]       dirty_d [SETS];
  logic [31:0]              data_q [SETS][WAY_CNT][WORDS];

  logic                     req, hit, dat_we, touch_fill;
  logic [WAY_W-1:0]         hit_way, vic_sel, repl_way, dat_way, touch_way;
  logic [LINE_ADDR_LEN-1:0] dat_word, word_off;
  logic [SET_ADDR_LEN-1:0]  set_idx;
  logic [TAG_LEN-1:0]       tag_in;
  logic [31:0]              dat_wdata, merged, miss_base;
  logic                     unused_addr_bits;

  assign req       = rd_req | wr_req;
  assign word_off  = addr[LINE_ADDR_LEN+1:2];
  assign set_idx   = addr[LINE_ADDR_LEN+2 +: SET_ADDR_LEN];
  assign tag_in    = addr[31 -: TAG_LEN];
  assign miss_base = {2'b00, tag_in, set_idx, {LINE_ADDR_LEN{1'b0}}};
  assign unused_addr_bits = ^addr[1:0];

  assign miss       = (state_q == WB) || (state_q == FILL) || (state_q == IDLE && req && !hit);
  assign rd_data    = rd_data_q;
  assign mem_rd_req = mem_rd_req_q;
  assign mem_wr_req = mem_wr_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign miss_cnt   = miss_cnt_q;

  // Tag lookup in the addressed set, plus byte-merge of store data into the hit word.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAY_CNT; w++) begin
      if (valid_q[set_idx][w] && tag_q[set_idx][w] == tag_in) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    merged = data_q[set_idx][hit_way][word_off];
    for (int b = 0; b < 4; b++)
      if (wr_be[b]) merged[8*b +: 8] = wr_data[8*b +: 8];
  end

  // Victim: lowest-index invalid way wins over the replacement policy's choice.
  always_comb begin
    vic_sel = repl_way;
    for (int w = WAY_CNT - 1; w >= 0; w--)
      if (!valid_q[set_idx][w]) vic_sel = WAY_W'(w);
  end

`ifdef DCACHE_LRU_EN
  logic [WAY_W-1:0] age_q [SETS][WAY_CNT];
  logic [WAY_W-1:0] age_d [SETS][WAY_CNT];
  logic [WAY_W-1:0] eff_age;
  logic             touch_hit;

  // Oldest way (maximum age, lowest index on ties) is the LRU victim.
  always_comb begin
    repl_way = '0;
    for (int w = 1; w < WAY_CNT; w++)
      if (age_q[set_idx][w] > age_q[set_idx][repl_way]) repl_way = WAY_W'(w);
  end

  // Touched way becomes youngest; an invalid way counts as oldest so ages stay a permutation.
  always_comb begin
    age_d   = age_q;
    eff_age = valid_q[set_idx][touch_way] ? age_q[set_idx][touch_way] : WAY_W'(WAY_CNT - 1);
    if (touch_hit || touch_fill) begin
      for (int w = 0; w < WAY_CNT; w++) begin
        if (WAY_W'(w) == touch_way) age_d[set_idx][w] = '0;
        else if (age_q[set_idx][w] < eff_age) age_d[set_idx][w] = age_q[set_idx][w] + 1'b1;
      end
    end
  end

  // Age counters, cleared on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) age_q <= '{default: '0};
    else      age_q <= age_d;
  end
`else
  logic [WAY_W-1:0] ptr_q [SETS];
  logic [WAY_W-1:0] ptr_d [SETS];

  assign repl_way = ptr_q[set_idx];

  // Round-robin pointer moves only when a line is filled; hits leave it alone.
  always_comb begin
    ptr_d = ptr_q;
    if (touch_fill)
      ptr_d[set_idx] = (ptr_q[set_idx] == WAY_W'(WAY_CNT - 1)) ? '0 : ptr_q[set_idx] + 1'b1;
  end

  // Round-robin pointers, cleared on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '{default: '0};
    else      ptr_q <= ptr_d;
  end
`endif

  // Controller: lookup/serve, write-back burst, fill burst, and the one-cycle replay in DONE.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    vic_d        = vic_q;
    rd_data_d    = rd_data_q;
    mem_rd_req_d = mem_rd_req_q;
    mem_wr_req_d = mem_wr_req_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    miss_cnt_d   = miss_cnt_q;
    tag_d        = tag_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    dat_we       = 1'b0;
    dat_way      = hit_way;
    dat_word     = word_off;
    dat_wdata    = merged;
    touch_fill   = 1'b0;
    touch_way    = hit_way;
`ifdef DCACHE_LRU_EN
    touch_hit    = 1'b0;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) state_d = IDLE;
        if (req && hit) begin
`ifdef DCACHE_LRU_EN
          touch_hit = 1'b1;
`endif
          if (wr_req) begin
            dat_we                    = 1'b1;
            dirty_d[set_idx][hit_way] = 1'b1;
          end else begin
            rd_data_d = data_q[set_idx][hit_way][word_off];
          end
        end else if (req && state_q == IDLE) begin
          miss_cnt_d = miss_cnt_q + 32'd1;
          vic_d      = vic_sel;
          beat_d     = '0;
          if (valid_q[set_idx][vic_sel] && dirty_q[set_idx][vic_sel]) begin
            state_d      = WB;
            mem_wr_req_d = 1'b1;
            mem_addr_d   = {2'b00, tag_q[set_idx][vic_sel], set_idx, {LINE_ADDR_LEN{1'b0}}};
            mem_wdata_d  = data_q[set_idx][vic_sel][0];
          end else begin
            state_d      = FILL;
            mem_rd_req_d = 1'b1;
            mem_addr_d   = miss_base;
          end
        end
      end
      WB: begin
        if (mem_ack) begin
          if (beat_q == LINE_ADDR_LEN'(WORDS - 1)) begin
            state_d      = FILL;
            mem_wr_req_d = 1'b0;
            mem_rd_req_d = 1'b1;
            mem_addr_d   = miss_base;
            beat_d       = '0;
          end else begin
            beat_d      = beat_q + 1'b1;
            mem_addr_d  = mem_addr_q + 32'd1;
            mem_wdata_d = data_q[set_idx][vic_q][beat_q + 1'b1];
          end
        end
      end
      FILL: begin
        if (mem_ack) begin
          dat_we    = 1'b1;
          dat_way   = vic_q;
          dat_word  = beat_q;
          dat_wdata = mem_rdata;
          if (beat_q == LINE_ADDR_LEN'(WORDS - 1)) begin
            state_d                 = DONE;
            mem_rd_req_d            = 1'b0;
            beat_d                  = '0;
            valid_d[set_idx][vic_q] = 1'b1;
            dirty_d[set_idx][vic_q] = 1'b0;
            tag_d[set_idx][vic_q]   = tag_in;
            touch_fill              = 1'b1;
            touch_way               = vic_q;
          end else begin
            beat_d     = beat_q + 1'b1;
            mem_addr_d = mem_addr_q + 32'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and tag state; reset aborts any burst and invalidates every line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      vic_q        <= '0;
      rd_data_q    <= '0;
      mem_rd_req_q <= 1'b0;
      mem_wr_req_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      miss_cnt_q   <= '0;
      tag_q        <= '{default: '0};
      valid_q      <= '{default: '0};
      dirty_q      <= '{default: '0};
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      vic_q        <= vic_d;
      rd_data_q    <= rd_data_d;
      mem_rd_req_q <= mem_rd_req_d;
      mem_wr_req_q <= mem_wr_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      miss_cnt_q   <= miss_cnt_d;
      tag_q        <= tag_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
    end
  end

  // Line data needs no reset: valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (dat_we) data_q[set_idx][dat_way][dat_word] <= dat_wdata;
  end
endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb: flat reference memory model, expected-load queue, logged memory beats.
module tb_dcache_wb;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_req = 1'b0, wr_req = 1'b0;
  logic [31:0] addr = '0, wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic [31:0] rd_data, mem_addr, mem_wdata, miss_cnt;
  logic        miss, mem_rd_req, mem_wr_req;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b1;

  dcache_wb dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req), .addr(addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_data(rd_data), .miss(miss),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
  } beat_t;

  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] exp_q [$];
  beat_t       log_q [$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          exp_miss = 0;
  int          cyc_cnt = 0;
  bit          ack_mode = 1'b0;
  bit          ack_par = 1'b0;

`ifdef DCACHE_LRU_EN
  localparam int T3_REREAD_CYC = 0;
`else
  localparam int T3_REREAD_CYC = 9;
`endif

  function automatic logic [31:0] init_val(input logic [31:0] w);
    if (w >= 32'h40 && w <= 32'h47) return 32'hA000_0000 + (w - 32'h40);
    return 32'hB000_0000 | w;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] w);
    if (mem.exists(w)) return mem[w];
    return init_val(w);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return init_val(w);
  endfunction

  function automatic beat_t mk_beat(input bit wr, input logic [31:0] a, input logic [31:0] d);
    beat_t b;
    b.wr = wr;
    b.a  = a;
    b.d  = d;
    return b;
  endfunction

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Memory responder: picks this cycle's ack, logs accepted beats, presents read data.
  always @(negedge clk) begin
    mem_ack = ack_mode ? (cyc_cnt[0] == ack_par) : 1'b1;
    if (mem_wr_req && mem_ack) begin
      mem[mem_addr] = mem_wdata;
      log_q.push_back(mk_beat(1'b1, mem_addr, mem_wdata));
    end
    if (mem_rd_req && mem_ack) log_q.push_back(mk_beat(1'b0, mem_addr, mem_rd(mem_addr)));
    mem_rdata = mem_rd(mem_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    ref_mem = mem;
    exp_miss = 0;
  endtask

  // One request; checks stall length, miss_cnt and, for loads, the popped expected data.
  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input int exp_cyc, input string tag);
    int          cyc;
    logic [31:0] m;
    @(negedge clk);
    log_q.delete();
    if (wr) begin
      m = ref_rd({2'b00, a[31:2]});
      for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = wd[8*b +: 8];
      ref_mem[{2'b00, a[31:2]}] = m;
    end else begin
      exp_q.push_back(ref_rd({2'b00, a[31:2]}));
    end
    wr_req = wr; rd_req = !wr; addr = a; wr_data = wd; wr_be = be;
    #1;
    cyc = 0;
    while (miss === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    check({tag, " miss cycles"}, 32'(cyc), 32'(exp_cyc));
    @(negedge clk);
    rd_req = 1'b0; wr_req = 1'b0;
    #1;
    if (exp_cyc > 0) exp_miss++;
    check({tag, " miss_cnt"}, miss_cnt, 32'(exp_miss));
    if (!wr) check({tag, " rd_data"}, rd_data, exp_q.pop_front());
  endtask

  task automatic check_burst(input string tag, input bit wr, input int first, input logic [31:0] base);
    for (int k = 0; k < 8; k++) begin
      if (first + k < log_q.size()) begin
        check({tag, " beat dir"}, 32'(log_q[first+k].wr), 32'(wr));
        check({tag, " beat addr"}, log_q[first+k].a, base + 32'(k));
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset rd_data", rd_data, 32'h0);
    check("reset miss", 32'(miss), 32'h0);
    check("reset mem_rd_req", 32'(mem_rd_req), 32'h0);
    check("reset mem_wr_req", 32'(mem_wr_req), 32'h0);
    check("reset mem_addr", mem_addr, 32'h0);
    check("reset mem_wdata", mem_wdata, 32'h0);
    check("reset miss_cnt", miss_cnt, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    ref_mem = mem;

    // Clean miss
    access(1'b0, 32'h100, 32'h0, 4'h0, 9, "t1 read 0x100");
    check("t1 beat count", 32'(log_q.size()), 32'd8);
    check_burst("t1 fill", 1'b0, 0, 32'h40);

    // Partial write hit, then read back
    access(1'b1, 32'h104, 32'hDEADBEEF, 4'b0011, 0, "t2 write 0x104");
    check("t2 write traffic", 32'(log_q.size()), 32'd0);
    access(1'b0, 32'h104, 32'h0, 4'h0, 0, "t2 read 0x104");
    check("t2 read traffic", 32'(log_q.size()), 32'd0);
    check("t2 merged value", rd_data, 32'hA000_BEEF);

    // Replacement order in set 0
    do_reset();
    access(1'b0, 32'h000, 32'h0, 4'h0, 9, "t3 read 0x000");
    access(1'b0, 32'h100, 32'h0, 4'h0, 9, "t3 read 0x100");
    access(1'b0, 32'h200, 32'h0, 4'h0, 9, "t3 read 0x200");
    access(1'b0, 32'h300, 32'h0, 4'h0, 9, "t3 read 0x300");
    access(1'b0, 32'h000, 32'h0, 4'h0, 0, "t3 hit 0x000");
    access(1'b0, 32'h400, 32'h0, 4'h0, 9, "t3 read 0x400");
    access(1'b0, 32'h000, 32'h0, 4'h0, T3_REREAD_CYC, "t3 reread 0x000");

    // Dirty eviction of the stored line
    do_reset();
    access(1'b1, 32'h100, 32'h11111111, 4'hF, 9, "t4 store 0x100");
    access(1'b0, 32'h000, 32'h0, 4'h0, 9, "t4 read 0x000");
    access(1'b0, 32'h100, 32'h0, 4'h0, 0, "t4 hit 0x100");
    access(1'b0, 32'h200, 32'h0, 4'h0, 9, "t4 read 0x200");
    access(1'b0, 32'h300, 32'h0, 4'h0, 9, "t4 read 0x300");
    access(1'b0, 32'h000, 32'h0, 4'h0, 0, "t4 hit 0x000");
    access(1'b0, 32'h400, 32'h0, 4'h0, 17, "t4 read 0x400");
    check("t4 beat count", 32'(log_q.size()), 32'd16);
    check_burst("t4 wb", 1'b1, 0, 32'h40);
    check_burst("t4 fill", 1'b0, 8, 32'h100);
    if (log_q.size() >= 2) begin
      check("t4 first wdata", log_q[0].d, 32'h11111111);
      check("t4 second wdata", log_q[1].d, 32'hA000_0001);
    end
    access(1'b0, 32'h100, 32'h0, 4'h0, 9, "t4 refetch 0x100");

    // Ack gaps: ack high in the request cycle, low in the first fill cycle, then alternating
    @(negedge clk);
    ack_par = ~cyc_cnt[0];
    ack_mode = 1'b1;
    access(1'b0, 32'h620, 32'h0, 4'h0, 17, "t5 gapped read 0x620");
    check("t5 beat count", 32'(log_q.size()), 32'd8);
    check_burst("t5 fill", 1'b0, 0, 32'h188);

    // Reset during a fill
    @(negedge clk);
    ack_mode = 1'b0;
    @(negedge clk);
    rd_req = 1'b1; addr = 32'h500;
    repeat (4) @(negedge clk);
    #2;
    check("t6 pre-reset mem_rd_req", 32'(mem_rd_req), 32'h1);
    check("t6 pre-reset mem_addr", mem_addr, 32'h143);
    rst = 1'b0; rd_req = 1'b0;
    #1;
    check("t6 mem_rd_req dropped", 32'(mem_rd_req), 32'h0);
    check("t6 miss_cnt cleared", miss_cnt, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    ref_mem = mem;
    exp_miss = 0;
    access(1'b0, 32'h500, 32'h0, 4'h0, 9, "t6 reread 0x500");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
